pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the hand-written per-stage registers (F/D, D/E, E/M, M/W) with one block that carries instruction, PC, delay-slot flag and exception code. It adds a valid/ready handshake, an optional skid buffer that keeps `in_ready` registered, NOP substitution on fetch-side exceptions, CP0 flush, and saturating stall/bubble counters.

## Interface
- `INSTR_W`, 32, instruction width
- `PC_W`, 32, PC width
- `EXC_W`, 5, exception-code width; 0 means no exception
- `SKID`, 1, 0 = single register; 1 = register plus one-entry skid buffer
- `CNT_W`, 16, performance counter width
- `Clk`  in  1  clock
- `Rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  CP0 exception entry or eret; empties the stage
- `in_valid`  in  1  upstream holds a valid entry
- `in_ready`  out  1  stage accepts the entry this cycle
- `in_instr`  in  INSTR_W  instruction word
- `in_pc`  in  PC_W  instruction PC
- `in_bd`  in  1  branch-delay-slot flag
- `in_exc`  in  EXC_W  exception code raised so far
- `out_valid`  out  1  stage holds a valid entry
- `out_ready`  in  1  downstream accepts; 0 = stall
- `out_instr`, `out_pc`, `out_pc8`, `out_bd`, `out_exc`  out  INSTR_W/PC_W/PC_W/1/EXC_W  registered entry
- `stall_cnt`  out  CNT_W  cycles with `out_valid & ~out_ready`
- `bubble_cnt`  out  CNT_W  cycles with `~out_valid & out_ready`

## Operation
- Entry fields: instr, pc, pc8, bd, exc. `pc8 = in_pc + 8` mod 2^PC_W, computed on capture.
- NOP substitution: if `in_exc != 0`, the captured instr is 0. pc, bd and exc are still captured so EPC and BD reach CP0.
- Accept: `in_valid & in_ready`. Drain: `out_valid & out_ready`.
- SKID=0:
  - `in_ready = ~out_valid | out_ready` (combinational).
  - When `in_ready` is high, `out_valid <= in_valid`. The entry loads on accept. All fields clear to 0 when `in_valid = 0` (bubble).
  - When `in_ready` is low, the stage holds.
- SKID=1: three states by occupancy.
  - EMPTY: main and skid both empty.
  - ONE: main full.
  - FULL: main and skid both full.
  - `in_ready = ~skid_valid` (registered, with no combinational path from `out_ready`).
  - EMPTY, accept → ONE.
  - ONE, accept with drain → ONE (new entry goes to main).
  - ONE, accept without drain → FULL (new entry goes to skid).
  - ONE, drain without accept → EMPTY.
  - FULL, drain → ONE (skid moves to main). No accept is possible in FULL.
  - Output order always equals input order.
- `flush`: on the next edge, all entries are invalid and all output fields are 0. Data accepted in the flush cycle is dropped. `flush` overrides accept and drain in the same cycle.
- Counters: sampled from pre-edge `out_valid`/`out_ready`. Each saturates at 2^CNT_W−1. Only `Rst` clears them; `flush` does not. They also count in flush cycles.

## Timing
- Reset values: `out_valid` = 0, all out fields = 0, skid empty, `stall_cnt` = 0, `bubble_cnt` = 0.
- `in_ready` out of reset: 1 (both modes).
- Latency: an accepted entry appears on the outputs one cycle later, in both modes.
- A skid entry reaches the outputs one edge after the drain of the main entry.
- Throughput: one entry per cycle with `out_ready` held high.
- SKID=1: `in_ready` falls the edge after entering FULL and rises the edge after leaving FULL.
- Reset or flush mid-stall, with either state occupied: both entries are discarded; the state is EMPTY at the next edge.
- PC wrap: `in_pc = 0xFFFFFFFC` gives `out_pc8 = 0x00000004`.

## Test plan
- Streaming, SKID=1: 4 entries at `in_pc` = 0x3000, 0x3004, 0x3008, 0x300C, `out_ready` = 1. Outputs appear in order, one cycle late. `out_pc8` = 0x3008…0x3014. `stall_cnt` = 0.
- Stall into skid, SKID=1: `out_ready = 0` while sending 0x3000 then 0x3004. State is FULL and `in_ready` = 0. Raise `out_ready`: 0x3000 then 0x3004 emerge with none lost or duplicated. `stall_cnt` equals the number of stall cycles.
- Exception NOP: `in_instr` = 0x8C010000, `in_exc` = 4, `in_bd` = 1, `in_pc` = 0x3001. Outputs: `out_instr` = 0, `out_exc` = 4, `out_bd` = 1, `out_pc` = 0x3001.
- Flush: in FULL, assert `flush` together with `in_valid`. Next cycle `out_valid` = 0, all fields 0, `in_ready` = 1. Counters keep their values.
- SKID=0 backpressure: `out_ready` = 0 with `out_valid` = 1 drives `in_ready` = 0 in the same cycle, and the entry holds. Idle input with `out_ready` = 1 increments `bubble_cnt` each cycle.
- Saturation and reset: with CNT_W = 4, stall 20 cycles → `stall_cnt` = 15. Assert `Rst` → counters and outputs return to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with valid/ready, optional skid entry,
// exception NOP substitution, flush and saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int EXC_W   = 5,
  parameter int SKID    = 1,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               in_bd,
  input  logic [EXC_W-1:0]   in_exc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc8,
  output logic               out_bd,
  output logic [EXC_W-1:0]   out_exc,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // A faulting fetch travels as a NOP but keeps pc/bd/exc so CP0 sees EPC and BD.
  logic [INSTR_W-1:0] cap_instr;
  logic [PC_W-1:0]    cap_pc8;

  assign cap_instr = (in_exc != '0) ? '0 : in_instr;
  assign cap_pc8   = in_pc + PC_W'(8);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && out_ready && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  generate
    if (SKID == 0) begin : g_single
      assign in_ready = ~out_valid | out_ready;

      always_ff @(posedge Clk) begin
        if (Rst || flush) begin
          out_valid <= 1'b0;
          out_instr <= '0;
          out_pc    <= '0;
          out_pc8   <= '0;
          out_bd    <= 1'b0;
          out_exc   <= '0;
        end else if (in_ready) begin
          out_valid <= in_valid;
          out_instr <= in_valid ? cap_instr : '0;
          out_pc    <= in_valid ? in_pc     : '0;
          out_pc8   <= in_valid ? cap_pc8   : '0;
          out_bd    <= in_valid ? in_bd     : 1'b0;
          out_exc   <= in_valid ? in_exc    : '0;
        end
      end
    end else begin : g_skid
      state_t             state_q, state_d;
      logic               accept, drain;
      logic               load_main, load_skid, move_skid, clear_main;
      logic [INSTR_W-1:0] skid_instr;
      logic [PC_W-1:0]    skid_pc;
      logic [PC_W-1:0]    skid_pc8;
      logic               skid_bd;
      logic [EXC_W-1:0]   skid_exc;

      // in_ready depends only on the state register, never on out_ready.
      assign in_ready  = (state_q != FULL);
      assign out_valid = (state_q != EMPTY);
      assign accept    = in_valid & in_ready;
      assign drain     = out_valid & out_ready;

      always_ff @(posedge Clk) begin
        if (Rst) state_q <= EMPTY;
        else     state_q <= state_d;
      end

      always_comb begin
        state_d    = state_q;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        clear_main = 1'b0;
        case (state_q)
          EMPTY: begin
            if (accept) begin
              load_main = 1'b1;
              state_d   = ONE;
            end
          end
          ONE: begin
            if (accept && drain) begin
              load_main = 1'b1;
            end else if (accept) begin
              load_skid = 1'b1;
              state_d   = FULL;
            end else if (drain) begin
              clear_main = 1'b1;
              state_d    = EMPTY;
            end
          end
          FULL: begin
            if (drain) begin
              move_skid = 1'b1;
              state_d   = ONE;
            end
          end
          default: state_d = EMPTY;
        endcase
        if (flush) begin
          state_d    = EMPTY;
          load_main  = 1'b0;
          load_skid  = 1'b0;
          move_skid  = 1'b0;
          clear_main = 1'b0;
        end
      end

      always_ff @(posedge Clk) begin
        if (Rst || flush) begin
          out_instr  <= '0;
          out_pc     <= '0;
          out_pc8    <= '0;
          out_bd     <= 1'b0;
          out_exc    <= '0;
          skid_instr <= '0;
          skid_pc    <= '0;
          skid_pc8   <= '0;
          skid_bd    <= 1'b0;
          skid_exc   <= '0;
        end else begin
          if (load_main) begin
            out_instr <= cap_instr;
            out_pc    <= in_pc;
            out_pc8   <= cap_pc8;
            out_bd    <= in_bd;
            out_exc   <= in_exc;
          end
          if (clear_main) begin
            out_instr <= '0;
            out_pc    <= '0;
            out_pc8   <= '0;
            out_bd    <= 1'b0;
            out_exc   <= '0;
          end
          if (load_skid) begin
            skid_instr <= cap_instr;
            skid_pc    <= in_pc;
            skid_pc8   <= cap_pc8;
            skid_bd    <= in_bd;
            skid_exc   <= in_exc;
          end
          if (move_skid) begin
            out_instr  <= skid_instr;
            out_pc     <= skid_pc;
            out_pc8    <= skid_pc8;
            out_bd     <= skid_bd;
            out_exc    <= skid_exc;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_pc8   <= '0;
            skid_bd    <= 1'b0;
            skid_exc   <= '0;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - bench for pipe_stage_reg: SKID=1/CNT_W=16 and SKID=0/CNT_W=4 side by side
// on shared inputs, each checked against a FIFO-occupancy reference model.
module tb_pipe_stage_reg;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        in_bd = 1'b0;
  logic [4:0]  in_exc = '0;
  logic        out_ready = 1'b0;

  logic        s_in_ready, s_out_valid, s_out_bd;
  logic [31:0] s_out_instr, s_out_pc, s_out_pc8;
  logic [4:0]  s_out_exc;
  logic [15:0] s_stall_cnt, s_bubble_cnt;

  logic        r_in_ready, r_out_valid, r_out_bd;
  logic [31:0] r_out_instr, r_out_pc, r_out_pc8;
  logic [4:0]  r_out_exc;
  logic [3:0]  r_stall_cnt, r_bubble_cnt;

  always #5 Clk = ~Clk;

  pipe_stage_reg #(.INSTR_W(32), .PC_W(32), .EXC_W(5), .SKID(1), .CNT_W(16)) dut_skid (
    .Clk(Clk), .Rst(Rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_bd(in_bd), .in_exc(in_exc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr), .out_pc(s_out_pc),
    .out_pc8(s_out_pc8), .out_bd(s_out_bd), .out_exc(s_out_exc),
    .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  pipe_stage_reg #(.INSTR_W(32), .PC_W(32), .EXC_W(5), .SKID(0), .CNT_W(4)) dut_reg (
    .Clk(Clk), .Rst(Rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_bd(in_bd), .in_exc(in_exc),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_instr(r_out_instr), .out_pc(r_out_pc),
    .out_pc8(r_out_pc8), .out_bd(r_out_bd), .out_exc(r_out_exc),
    .stall_cnt(r_stall_cnt), .bubble_cnt(r_bubble_cnt)
  );

  // Entries packed as {instr, pc, pc8, bd, exc}; each stage is modelled as a bounded FIFO.
  logic [101:0] qs[$];
  logic [101:0] qr[$];
  int sc_s = 0, bc_s = 0, sc_r = 0, bc_r = 0;
  int checks = 0;
  int errors = 0;

  function automatic logic [101:0] make_entry();
    logic [31:0] ins;
    ins = (in_exc != 5'd0) ? 32'd0 : in_instr;
    return {ins, in_pc, in_pc + 32'd8, in_bd, in_exc};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic acc_s, drn_s, acc_r, drn_r;
    if (Rst) begin
      qs.delete(); qr.delete();
      sc_s = 0; bc_s = 0; sc_r = 0; bc_r = 0;
      return;
    end
    if (qs.size() > 0 && !out_ready && sc_s < 65535) sc_s++;
    if (qs.size() == 0 && out_ready && bc_s < 65535) bc_s++;
    if (qr.size() > 0 && !out_ready && sc_r < 15) sc_r++;
    if (qr.size() == 0 && out_ready && bc_r < 15) bc_r++;
    acc_s = in_valid && (qs.size() < 2);
    drn_s = (qs.size() > 0) && out_ready;
    acc_r = in_valid && (qr.size() == 0 || out_ready);
    drn_r = (qr.size() > 0) && out_ready;
    if (flush) begin
      qs.delete(); qr.delete();
    end else begin
      if (drn_s) void'(qs.pop_front());
      if (acc_s) qs.push_back(make_entry());
      if (drn_r) void'(qr.pop_front());
      if (acc_r) qr.push_back(make_entry());
    end
  endtask

  // Inputs are already applied; check ready, advance one edge, check registered outputs.
  task automatic step();
    logic [101:0] es, er;
    #1;
    if (!Rst) begin
      chk("skid_in_ready", s_in_ready, qs.size() < 2);
      chk("reg_in_ready", r_in_ready, (qr.size() == 0) || out_ready);
    end
    model_edge();
    @(posedge Clk);
    #1;
    es = (qs.size() > 0) ? qs[0] : '0;
    er = (qr.size() > 0) ? qr[0] : '0;
    chk("skid_out_valid", s_out_valid, qs.size() > 0);
    chk("skid_fields", {s_out_instr, s_out_pc, s_out_pc8, s_out_bd, s_out_exc}, es);
    chk("skid_stall_cnt", s_stall_cnt, sc_s);
    chk("skid_bubble_cnt", s_bubble_cnt, bc_s);
    chk("reg_out_valid", r_out_valid, qr.size() > 0);
    chk("reg_fields", {r_out_instr, r_out_pc, r_out_pc8, r_out_bd, r_out_exc}, er);
    chk("reg_stall_cnt", r_stall_cnt, sc_r);
    chk("reg_bubble_cnt", r_bubble_cnt, bc_r);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic bd, input logic [4:0] exc, input logic ordy);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    in_bd     = bd;
    in_exc    = exc;
    out_ready = ordy;
  endtask

  initial begin
    // Reset
    Rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    step();
    Rst = 1'b0;
    chk("reset_skid_in_ready", s_in_ready, 1'b1);
    chk("reset_reg_in_ready", r_in_ready, 1'b1);

    // Streaming at full rate
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h2000_0000 + 32'(i), 32'h3000 + 32'(4 * i), 1'b0, 5'd0, 1'b1);
      step();
      chk("stream_pc8", s_out_pc8, 32'h3008 + 32'(4 * i));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
    step();
    step();

    // Stall into skid, then release
    drive(1'b1, 32'h1111_1111, 32'h3000, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h2222_2222, 32'h3004, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'h3333_3333, 32'h3008, 1'b0, 5'd0, 1'b0);
    step();
    chk("full_in_ready_low", s_in_ready, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
    step();
    chk("skid_drain_pc", s_out_pc, 32'h3004);
    step();
    step();

    // Exception NOP and PC wrap
    drive(1'b1, 32'h8C01_0000, 32'h3001, 1'b1, 5'd4, 1'b1);
    step();
    chk("nop_instr", s_out_instr, 32'h0);
    chk("nop_exc", s_out_exc, 5'd4);
    drive(1'b1, 32'h0000_0020, 32'hFFFF_FFFC, 1'b0, 5'd0, 1'b1);
    step();
    chk("pc_wrap", s_out_pc8, 32'h0000_0004);

    // Flush while FULL, with a new entry offered in the same cycle
    drive(1'b1, 32'hAAAA_0001, 32'h4000, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b1, 32'hAAAA_0002, 32'h4004, 1'b0, 5'd0, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 32'hAAAA_0003, 32'h4008, 1'b0, 5'd0, 1'b0);
    step();
    flush = 1'b0;
    chk("flush_in_ready", s_in_ready, 1'b1);
    chk("flush_valid", s_out_valid, 1'b0);

    // Reset, then 20 stall cycles saturate the 4-bit counters
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    drive(1'b1, 32'h5555_0000, 32'h5000, 1'b0, 5'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("reg_stall_saturated", r_stall_cnt, 4'd15);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("reset_counters", {s_stall_cnt, r_stall_cnt, s_bubble_cnt, r_bubble_cnt}, 40'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      Rst   = ($urandom_range(0, 80) == 0);
      flush = ($urandom_range(0, 20) == 0);
      drive($urandom_range(0, 9) < 7, $urandom(),
            ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
            $urandom_range(0, 9) < 6);
      step();
    end
    Rst = 1'b0;
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
